// File: rtl/popcount_pattern_decoder_if.sv
// Request, serial and parallel-result signals of the popcount pattern decoder.
// The master side issues y/s requests and consumes x; the slave side is the decoder.
interface popcount_pattern_decoder_if #(
  parameter int N  = 7,
  parameter int CW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] y;
  logic [1:0]    s;
  logic          sdo;
  logic          sdo_en;
  logic [N-1:0]  x;
  logic          x_valid;
  logic          x_ready;

  modport master (
    output in_valid, y, s, x_ready,
    input  in_ready, sdo, sdo_en, x, x_valid
  );

  modport slave (
    input  in_valid, y, s, x_ready,
    output in_ready, sdo, sdo_en, x, x_valid
  );
endinterface

// File: rtl/popcount_pattern_decoder.sv
// Rebuilds an N-bit word holding min(y,N) ones placed by mode s, shifts it out LSB first,
// then presents it in parallel until the consumer takes it.
module popcount_pattern_decoder #(
  parameter int N   = 7,
  parameter int CW  = 3,
  parameter int ROT = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  popcount_pattern_decoder_if.slave   bus
);
  localparam int IW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    HOLD  = 2'b10
  } state_t;

  // Expands (count, mode) into the placed pattern; the count saturates at N.
  function automatic logic [N-1:0] pattern_f(input logic [CW-1:0] yv, input logic [1:0] sv);
    int           c;
    int           d;
    logic [N-1:0] p;
    c = (int'(yv) > N) ? N : int'(yv);
    p = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      d = (i - ROT + N) % N;
      case (sv)
        2'b00:   p[i] = (i < c);
        2'b01:   p[i] = (i >= N - c);
        2'b10:   p[i] = ((i % 2) == 0) ? ((i / 2) < c) : (((N + 1) / 2 + i / 2) < c);
        2'b11:   p[i] = (d < c);
        default: p[i] = 1'b0;
      endcase
    end
    return p;
  endfunction

  state_t          state_r, state_s;
  logic [IW-1:0]   idx_r, idx_s;
  logic [N-1:0]    pat_r, pat_s;
  logic [N-1:0]    pat_in_s;
  logic            sdo_r, sdo_s;
  logic            sdo_en_r, sdo_en_s;
  logic [N-1:0]    x_r, x_s;
  logic            x_valid_r, x_valid_s;
  logic            in_ready_r, in_ready_s;

  assign pat_in_s = pattern_f(bus.y, bus.s);

  // Next-state and next-output decode; idx counts the next bit to emit.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    pat_s      = pat_r;
    sdo_s      = 1'b0;
    sdo_en_s   = 1'b0;
    x_s        = x_r;
    x_valid_s  = 1'b0;
    in_ready_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          state_s  = SHIFT;
          pat_s    = pat_in_s;
          idx_s    = IW'(1);
          sdo_s    = pat_in_s[0];
          sdo_en_s = 1'b1;
          x_s      = {{(N-1){1'b0}}, pat_in_s[0]};
        end else begin
          in_ready_s = 1'b1;
        end
      end
      SHIFT: begin
        if (idx_r == IW'(N)) begin
          state_s   = HOLD;
          x_valid_s = 1'b1;
        end else begin
          sdo_s       = pat_r[idx_r];
          sdo_en_s    = 1'b1;
          x_s[idx_r]  = pat_r[idx_r];
          idx_s       = idx_r + IW'(1);
        end
      end
      HOLD: begin
        if (bus.x_ready) begin
          state_s    = IDLE;
          in_ready_s = 1'b1;
        end else begin
          x_valid_s = 1'b1;
        end
      end
      default: begin
        state_s    = IDLE;
        in_ready_s = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset discards any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      idx_r      <= {IW{1'b0}};
      pat_r      <= {N{1'b0}};
      sdo_r      <= 1'b0;
      sdo_en_r   <= 1'b0;
      x_r        <= {N{1'b0}};
      x_valid_r  <= 1'b0;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      pat_r      <= pat_s;
      sdo_r      <= sdo_s;
      sdo_en_r   <= sdo_en_s;
      x_r        <= x_s;
      x_valid_r  <= x_valid_s;
      in_ready_r <= in_ready_s;
    end
  end

  assign bus.sdo      = sdo_r;
  assign bus.sdo_en   = sdo_en_r;
  assign bus.x        = x_r;
  assign bus.x_valid  = x_valid_r;
  assign bus.in_ready = in_ready_r;
endmodule

// File: tb/tb_popcount_pattern_decoder.sv
// Randomised and directed bench for popcount_pattern_decoder, checked every cycle
// against a position-order reference model.
module tb_popcount_pattern_decoder;
  localparam int N   = 7;
  localparam int CW  = 3;
  localparam int ROT = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  popcount_pattern_decoder_if #(.N(N), .CW(CW)) bus ();

  popcount_pattern_decoder #(.N(N), .CW(CW), .ROT(ROT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: list the positions in fill order for the mode, then set the first c of them.
  function automatic logic [N-1:0] ref_pattern(input int yv, input int sv);
    int           order[$];
    int           c;
    logic [N-1:0] p;
    p = {N{1'b0}};
    c = (yv > N) ? N : yv;
    case (sv)
      0: for (int i = 0; i < N; i++) order.push_back(i);
      1: for (int i = N - 1; i >= 0; i--) order.push_back(i);
      2: begin
        for (int i = 0; i < N; i += 2) order.push_back(i);
        for (int i = 1; i < N; i += 2) order.push_back(i);
      end
      default: for (int k = 0; k < N; k++) order.push_back((ROT + k) % N);
    endcase
    for (int k = 0; k < c; k++) p[order[k]] = 1'b1;
    return p;
  endfunction

  // Model timeline: m_t counts cycles since accept (1..N shifting, N+1 holding).
  logic         m_busy   = 1'b0;
  int           m_t      = 0;
  logic [N-1:0] m_pat    = '0;
  logic [N-1:0] m_last_x = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy   <= 1'b0;
      m_t      <= 0;
      m_pat    <= '0;
      m_last_x <= '0;
    end else if (!m_busy) begin
      if (bus.in_valid) begin
        m_busy <= 1'b1;
        m_t    <= 1;
        m_pat  <= ref_pattern(int'(bus.y), int'(bus.s));
      end
    end else if (m_t <= N) begin
      m_t <= m_t + 1;
    end else if (bus.x_ready) begin
      m_busy   <= 1'b0;
      m_last_x <= m_pat;
    end
  end

  always @(negedge clk) begin
    if (!m_busy) begin
      check("idle_in_ready", 32'(bus.in_ready), 32'd1);
      check("idle_sdo_en",   32'(bus.sdo_en),   32'd0);
      check("idle_sdo",      32'(bus.sdo),      32'd0);
      check("idle_x_valid",  32'(bus.x_valid),  32'd0);
      check("idle_x",        32'(bus.x),        32'(m_last_x));
    end else if (m_t <= N) begin
      check("shift_in_ready", 32'(bus.in_ready), 32'd0);
      check("shift_sdo_en",   32'(bus.sdo_en),   32'd1);
      check("shift_sdo",      32'(bus.sdo),      32'(m_pat[m_t-1]));
      check("shift_x_valid",  32'(bus.x_valid),  32'd0);
    end else begin
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_sdo_en",   32'(bus.sdo_en),   32'd0);
      check("hold_sdo",      32'(bus.sdo),      32'd0);
      check("hold_x_valid",  32'(bus.x_valid),  32'd1);
      check("hold_x",        32'(bus.x),        32'(m_pat));
    end
  end

  int cyc = 0;
  int acc_times[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && bus.in_valid && bus.in_ready) acc_times.push_back(cyc);
  end

  task automatic wait_ready();
    int k = 0;
    while (!bus.in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_wait", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic send(input int yv, input int sv);
    wait_ready();
    bus.y        = CW'(yv);
    bus.s        = 2'(sv);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_xvalid();
    int k = 0;
    while (!bus.x_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("x_valid_wait", 32'(bus.x_valid), 32'd1);
  endtask

  task automatic release_x(input int stall);
    repeat (stall) @(negedge clk);
    bus.x_ready = 1'b1;
    @(negedge clk);
    bus.x_ready = 1'b0;
  endtask

  task automatic run_lit(input int yv, input int sv, input logic [N-1:0] exp, input string name);
    send(yv, sv);
    wait_xvalid();
    check(name, 32'(bus.x), 32'(exp));
    release_x(0);
  endtask

  initial begin
    logic [N-1:0] cap;
    logic [N-1:0] xs;
    int           en_cnt;
    int           yv;
    int           sv;
    int           k;

    bus.in_valid = 1'b0;
    bus.y        = '0;
    bus.s        = '0;
    bus.x_ready  = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_x",        32'(bus.x),        32'd0);
    check("rst_x_valid",  32'(bus.x_valid),  32'd0);
    check("rst_sdo_en",   32'(bus.sdo_en),   32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Serial thermometer: bits captured LSB first.
    send(3, 0);
    cap    = '0;
    en_cnt = 0;
    for (int i = 0; i < N; i++) begin
      cap[i] = bus.sdo;
      en_cnt += int'(bus.sdo_en);
      check("t1_busy_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    check("t1_sdo_seq", 32'(cap), 32'h07);
    check("t1_sdo_en_cnt", 32'(en_cnt), 32'd7);
    check("t1_x", 32'(bus.x), 32'h07);
    check("t1_x_valid", 32'(bus.x_valid), 32'd1);
    check("t1_hold_ready", 32'(bus.in_ready), 32'd0);
    release_x(0);
    check("t1_ready_back", 32'(bus.in_ready), 32'd1);

    run_lit(3, 1, 7'b1110000, "mode01_y3");
    run_lit(5, 2, 7'b1010111, "mode10_y5");
    run_lit(2, 3, 7'b0011000, "mode11_y2");
    run_lit(5, 3, 7'b1111001, "mode11_y5_wrap");

    // All count/mode combinations.
    for (int s2 = 0; s2 < 4; s2++) begin
      for (int y2 = 0; y2 < 8; y2++) begin
        send(y2, s2);
        wait_xvalid();
        check("popcount", 32'($countones(bus.x)), 32'((y2 > N) ? N : y2));
        if (y2 == 0) check("y0_zero", 32'(bus.x), 32'h00);
        if (y2 == 7) check("y7_full", 32'(bus.x), 32'h7f);
        release_x(0);
      end
    end

    // Backpressure in HOLD.
    send(4, 2);
    wait_xvalid();
    xs = bus.x;
    check("bp_x_value", 32'(xs), 32'h55);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_x_stable", 32'(bus.x), 32'(xs));
      check("bp_valid_stable", 32'(bus.x_valid), 32'd1);
    end
    bus.x_ready = 1'b1;
    @(negedge clk);
    bus.x_ready = 1'b0;
    check("bp_valid_drop", 32'(bus.x_valid), 32'd0);
    check("bp_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp_x_kept", 32'(bus.x), 32'(xs));

    // Back-to-back requests with the consumer always ready.
    acc_times.delete();
    bus.y        = CW'(6);
    bus.s        = 2'd1;
    bus.in_valid = 1'b1;
    bus.x_ready  = 1'b1;
    k = 0;
    while (acc_times.size() < 2 && k < 40) begin
      @(negedge clk);
      k++;
    end
    bus.in_valid = 1'b0;
    bus.x_ready  = 1'b0;
    if (acc_times.size() >= 2) check("b2b_gap", 32'(acc_times[1] - acc_times[0]), 32'd9);
    else check("b2b_accepts", 32'(acc_times.size()), 32'd2);
    wait_xvalid();
    check("b2b_x", 32'(bus.x), 32'h7e);
    release_x(0);

    // in_valid toggling while busy must not disturb the pattern.
    send(2, 0);
    for (int i = 0; i < N; i++) begin
      bus.in_valid = i[0];
      bus.y        = CW'(6);
      bus.s        = 2'd3;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("busy_x", 32'(bus.x), 32'h03);
    check("busy_x_valid", 32'(bus.x_valid), 32'd1);
    release_x(0);

    // Asynchronous reset while bit 4 is on sdo.
    send(5, 0);
    repeat (4) @(negedge clk);
    check("arst_pre_sdo_en", 32'(bus.sdo_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sdo_en", 32'(bus.sdo_en), 32'd0);
    check("arst_x_valid", 32'(bus.x_valid), 32'd0);
    check("arst_x", 32'(bus.x), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    run_lit(1, 0, 7'b0000001, "post_rst_y1");

    // Random traffic with random gaps and backpressure.
    for (int i = 0; i < 40; i++) begin
      yv = int'($urandom_range(0, 7));
      sv = int'($urandom_range(0, 3));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(yv, sv);
      wait_xvalid();
      check("rnd_popcount", 32'($countones(bus.x)), 32'(yv));
      release_x(int'($urandom_range(0, 4)));
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "timeout");
  end
endmodule
